// File: rtl/mul_div_iter.sv
// mul_div_iter: iterative radix-2 restoring divider for DIV/DIVU.
// Quotient goes to LO, remainder to HI. One quotient bit per BUSY cycle,
// followed by one sign-fixup cycle, so the result appears WIDTH+1 cycles
// after accept.
// Optional build macro: DIV_EARLY_EXIT_EN -- when |x| < |y| (and y != 0)
// the iteration is skipped and the result (quotient 0, remainder x) is
// presented one cycle after accept.
module mul_div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             sign_r;
  logic             y_zero;
  logic [WIDTH-1:0] mag_y;
  logic [WIDTH-1:0] x_orig;
  // Dividend magnitude shifts out of the top while quotient bits shift in.
  logic [WIDTH-1:0] quo_sh;
  // Partial remainder; stays below |y| between steps.
  logic [WIDTH:0]   rem_part;
`ifdef DIV_EARLY_EXIT_EN
  logic             early;
`endif

  logic             accept;
  logic             fixup;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  // Operand magnitudes, accept strobe and the final-cycle strobe.
  always_comb begin
    x_mag  = (div_signed && x[WIDTH-1]) ? -x : x;
    y_mag  = (div_signed && y[WIDTH-1]) ? -y : y;
    accept = (state == S_IDLE) && div_valid && !cancel;
    fixup  = (state == S_BUSY) && (cnt == CNT_W'(WIDTH));
`ifdef DIV_EARLY_EXIT_EN
    if ((state == S_BUSY) && early) fixup = 1'b1;
`endif
  end

  // One restoring step: shift in the next dividend bit, trial-subtract |y|.
  always_comb begin
    trial    = {rem_part, quo_sh[WIDTH-1]} - {2'b00, mag_y};
    trial_ok = !trial[WIDTH+1];
    rem_next = trial_ok ? trial[WIDTH:0] : {rem_part[WIDTH-1:0], quo_sh[WIDTH-1]};
  end

  // Sign correction and divide-by-zero override of the finished magnitudes.
  always_comb begin
    q_mag = quo_sh;
    r_mag = rem_part[WIDTH-1:0];
`ifdef DIV_EARLY_EXIT_EN
    if (early) begin
      q_mag = '0;
      r_mag = quo_sh;
    end
`endif
    if (y_zero) begin
      q_fin = '1;
      r_fin = x_orig;
    end else begin
      q_fin = sign_q ? -q_mag : q_mag;
      r_fin = sign_r ? -r_mag : r_mag;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; cancel overrides every other transition.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt
    // unassigned, which would infer a latch.
    state_nxt = state;
    case (state)
      S_IDLE:  if (div_valid) state_nxt = S_BUSY;
      S_BUSY:  if (fixup)     state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
    if (cancel) state_nxt = S_IDLE;
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    div_ready = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
  end

  // Datapath: operand capture, iteration, and result registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      y_zero    <= 1'b0;
      mag_y     <= '0;
      x_orig    <= '0;
      quo_sh    <= '0;
      rem_part  <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_EARLY_EXIT_EN
      early     <= 1'b0;
`endif
    end else if (accept) begin
      cnt      <= '0;
      sign_q   <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
      sign_r   <= div_signed & x[WIDTH-1];
      y_zero   <= (y == '0);
      mag_y    <= y_mag;
      x_orig   <= x;
      quo_sh   <= x_mag;
      rem_part <= '0;
`ifdef DIV_EARLY_EXIT_EN
      early    <= (y != '0) && (x_mag < y_mag);
`endif
    end else if (state == S_BUSY) begin
      cnt <= cnt + 1'b1;
      if (fixup) begin
        if (!cancel) begin
          quotient  <= q_fin;
          remainder <= r_fin;
        end
      end else begin
        rem_part <= rem_next;
        quo_sh   <= {quo_sh[WIDTH-2:0], trial_ok};
      end
    end
  end

endmodule

// File: tb/tb_mul_div_iter.sv
// tb_mul_div_iter: table-driven and randomized checks of mul_div_iter
// against a plain-arithmetic division model.
module tb_mul_div_iter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             div_valid;
  logic             div_ready;
  logic             div_signed;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cancel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  mul_div_iter #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .div_signed(div_signed),
    .x         (x),
    .y         (y),
    .cancel    (cancel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference division from the architectural rules.
  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  function automatic int exp_latency(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    ma = (sgn && a[31]) ? -longint'($signed(a)) : longint'(a);
    mb = (sgn && b[31]) ? -longint'($signed(b)) : longint'(b);
`ifdef DIV_EARLY_EXIT_EN
    if (b != 0 && ma < mb) return 1;
`endif
    if (ma < 0 || mb < 0) return -1;
    return WIDTH + 1;
  endfunction

  // Issue one request, wait (bounded) for out_valid, optionally consume it.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input bit do_release,
                        output logic [31:0] q, output logic [31:0] r, output int lat);
    @(negedge clk);
    div_signed = sgn;
    x          = a;
    y          = b;
    div_valid  = 1'b1;
    @(posedge clk);
    #1;
    div_valid  = 1'b0;
    // Scramble operands: the block must have captured them at accept.
    x          = $urandom;
    y          = $urandom;
    div_signed = 1'($urandom);
    if (!out_valid) begin
      check("busy_while_running", busy, 1);
      check("ready_low_while_running", div_ready, 0);
    end
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q = quotient;
    r = remainder;
    if (do_release) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("ready_after_release", div_ready, 1);
    end
  endtask

  vec_t        vecs[11];
  logic [31:0] q, r, eq, er;
  int          lat;
  bit          seen;

  initial begin
    rst        = 1'b1;
    div_valid  = 1'b0;
    div_signed = 1'b0;
    x          = '0;
    y          = '0;
    cancel     = 1'b0;
    out_ready  = 1'b0;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    vecs[5]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0};
    vecs[6]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3};
    vecs[7]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[9]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE};
    vecs[10] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_div_ready", div_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);

    // Directed vectors.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].sgn, vecs[i].x, vecs[i].y, 1'b1, q, r, lat);
      check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
      check($sformatf("vec%0d_latency", i), 64'(lat),
            64'(exp_latency(vecs[i].sgn, vecs[i].x, vecs[i].y)));
    end

    // Backpressure: result held while out_ready stays low.
    run_op(1'b0, 32'd1000, 32'd33, 1'b0, q, r, lat);
    check("bp_quotient", q, 30);
    check("bp_remainder", r, 10);
    div_valid = 1'b1;
    x         = 32'd5;
    y         = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_ready", div_ready, 0);
      check("bp_hold_quotient", quotient, 30);
      check("bp_hold_remainder", remainder, 10);
    end
    div_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_ready", div_ready, 1);
    check("bp_release_valid", out_valid, 0);

    // Cancel wins over a request presented in IDLE.
    @(negedge clk);
    div_valid = 1'b1;
    cancel    = 1'b1;
    x         = 32'd50;
    y         = 32'd5;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    cancel    = 1'b0;
    check("idle_cancel_not_accepted", div_ready, 1);
    check("idle_cancel_busy", busy, 0);

    // Cancel in the twelfth BUSY cycle.
    @(negedge clk);
    div_signed = 1'b0;
    x          = 32'd100;
    y          = 32'd7;
    div_valid  = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("pre_cancel_busy", busy, 1);
    cancel    = 1'b1;
    div_valid = 1'b1;
    @(posedge clk);
    #1;
    cancel    = 1'b0;
    div_valid = 1'b0;
    check("cancel_ready", div_ready, 1);
    check("cancel_busy", busy, 0);
    check("cancel_valid", out_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("cancel_no_result", seen, 0);
    run_op(1'b0, 32'd9, 32'd3, 1'b1, q, r, lat);
    check("post_cancel_quotient", q, 3);
    check("post_cancel_remainder", r, 0);
    check("post_cancel_latency", 64'(lat), 64'(exp_latency(1'b0, 32'd9, 32'd3)));

    // Synchronous reset in the middle of BUSY.
    @(negedge clk);
    div_signed = 1'b0;
    x          = 32'hFFFF;
    y          = 32'd3;
    div_valid  = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_div_ready", div_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic        sgn;
      logic [31:0] a, b;
      sgn = 1'($urandom);
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 20));
        1:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      ref_div(sgn, a, b, eq, er);
      run_op(sgn, a, b, 1'b1, q, r, lat);
      check($sformatf("rand%0d_quotient", i), q, eq);
      check($sformatf("rand%0d_remainder", i), r, er);
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'(exp_latency(sgn, a, b)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
